fetch_pc_unit: RTL and testbench

- Consumer side of the branch-control decision: owns the architectural fetch PC.
- Applies the 2-bit next-PC select produced in EX, drives the instruction-memory address, and flushes wrong-path instructions in IF/ID and ID/EX.
- Holds the PC under hazard stalls, traps on misaligned redirect targets, and counts taken redirects.
- Sits between the EX-stage branch/ALU outputs and the IF stage.

---
 rtl/fetch_pc_unit_if.sv | 30 +++
 rtl/fetch_pc_unit.sv | 89 ++++++++
 tb/tb_fetch_pc_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Bundles the EX-stage redirect inputs and the IF-stage fetch outputs.
// The PC unit takes the slave modport; the driving pipeline takes the master modport.
interface fetch_pc_unit_if;
  logic [1:0]  i_pc_sel;
  logic        i_redirect_valid;
  logic [31:0] i_jump_target;
  logic [31:0] i_branch_target;
  logic        i_stall;
  logic [31:0] o_imem_addr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_fetch_valid;
  logic        o_flush_if_id;
  logic        o_flush_id_ex;
  logic        o_trap;
  logic [31:0] o_trap_pc;
  logic [31:0] o_redirect_count;

  modport master (
    output i_pc_sel, i_redirect_valid, i_jump_target, i_branch_target, i_stall,
    input  o_imem_addr, o_pc, o_pc_plus4, o_fetch_valid, o_flush_if_id,
           o_flush_id_ex, o_trap, o_trap_pc, o_redirect_count
  );

  modport slave (
    input  i_pc_sel, i_redirect_valid, i_jump_target, i_branch_target, i_stall,
    output o_imem_addr, o_pc, o_pc_plus4, o_fetch_valid, o_flush_if_id,
           o_flush_id_ex, o_trap, o_trap_pc, o_redirect_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Owns the architectural fetch PC: applies EX redirects, flushes wrong-path
// stages, holds under stalls, and halts on a misaligned redirect target.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  fetch_pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] count_q, count_d;
  logic        fetch_valid;
  logic        flush;
  logic        redirect;
  logic [31:0] target;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_d      = trap_q;
    trap_pc_d   = trap_pc_q;
    count_d     = count_q;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    redirect    = bus.i_redirect_valid & bus.i_pc_sel[0];
    // Jump targets come from jalr-style ALU results, so bit 0 is dropped.
    target      = bus.i_pc_sel[1] ? bus.i_branch_target
                                  : {bus.i_jump_target[31:1], 1'b0};
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        fetch_valid = 1'b1;
        if (redirect) begin
          flush = 1'b1;
          if (target[1]) begin
            state_d   = HALT;
            trap_d    = 1'b1;
            trap_pc_d = target;
          end else begin
            pc_d    = target;
            count_d = count_q + 32'd1;
          end
        end else if (!bus.i_stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
    // Squash all combinational strobes while reset is held.
    if (!i_rst_n) begin
      fetch_valid = 1'b0;
      flush       = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_ADDR;
      trap_q    <= 1'b0;
      trap_pc_q <= 32'h0;
      count_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
      count_q   <= count_d;
    end
  end

  assign bus.o_pc             = pc_q;
  assign bus.o_imem_addr      = pc_q;
  assign bus.o_pc_plus4       = pc_q + 32'd4;
  assign bus.o_fetch_valid    = fetch_valid;
  assign bus.o_flush_if_id    = flush;
  assign bus.o_flush_id_ex    = flush;
  assign bus.o_trap           = trap_q;
  assign bus.o_trap_pc        = trap_pc_q;
  assign bus.o_redirect_count = count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with RESET_ADDR = 0x100; expected values
// are hand-computed per scenario.
module tb_fetch_pc_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_ADDR(32'h0000_0100)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic v, input logic [1:0] sel,
                            input logic [31:0] jt, input logic [31:0] bt,
                            input logic st);
    bus.i_redirect_valid = v;
    bus.i_pc_sel         = sel;
    bus.i_jump_target    = jt;
    bus.i_branch_target  = bt;
    bus.i_stall          = st;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_inputs(1'b1, 2'b11, 32'h0, 32'h80, 1'b0);
    tick();
    checks++; if (bus.o_pc !== 32'h100) begin errors++; $display("[TB] FAIL reset_pc got %h exp %h", bus.o_pc, 32'h100); end
    checks++; if (bus.o_imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL reset_imem got %h exp %h", bus.o_imem_addr, 32'h100); end
    checks++; if (bus.o_trap !== 1'b0) begin errors++; $display("[TB] FAIL reset_trap got %b exp 0", bus.o_trap); end
    checks++; if (bus.o_trap_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_trap_pc got %h exp 0", bus.o_trap_pc); end
    checks++; if (bus.o_redirect_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_count got %h exp 0", bus.o_redirect_count); end
    checks++; if (bus.o_fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_valid got %b exp 0", bus.o_fetch_valid); end
    checks++; if (bus.o_flush_if_id !== 1'b0 || bus.o_flush_id_ex !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush got %b%b exp 00", bus.o_flush_if_id, bus.o_flush_id_ex); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.o_fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_fetch_valid got %b exp 0", bus.o_fetch_valid); end
    checks++; if (bus.o_flush_if_id !== 1'b0 || bus.o_flush_id_ex !== 1'b0) begin errors++; $display("[TB] FAIL boot_flush got %b%b exp 00", bus.o_flush_if_id, bus.o_flush_id_ex); end
    tick();
    set_inputs(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (bus.o_pc !== 32'h100) begin errors++; $display("[TB] FAIL run0_pc got %h exp %h", bus.o_pc, 32'h100); end
    checks++; if (bus.o_fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL run0_fetch_valid got %b exp 1", bus.o_fetch_valid); end
    checks++; if (bus.o_pc_plus4 !== 32'h104) begin errors++; $display("[TB] FAIL run0_plus4 got %h exp %h", bus.o_pc_plus4, 32'h104); end
    tick();
    checks++; if (bus.o_pc !== 32'h104) begin errors++; $display("[TB] FAIL run1_pc got %h exp %h", bus.o_pc, 32'h104); end
    tick();
    checks++; if (bus.o_pc !== 32'h108) begin errors++; $display("[TB] FAIL run2_pc got %h exp %h", bus.o_pc, 32'h108); end
    checks++; if (bus.o_redirect_count !== 32'h0) begin errors++; $display("[TB] FAIL run2_count got %h exp 0", bus.o_redirect_count); end
  endtask

  task automatic test_branch();
    set_inputs(1'b1, 2'b01, 32'h20, 32'h0, 1'b0);
    #1;
    checks++; if (bus.o_flush_if_id !== 1'b1 || bus.o_flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL jump20_flush got %b%b exp 11", bus.o_flush_if_id, bus.o_flush_id_ex); end
    tick();
    checks++; if (bus.o_pc !== 32'h20) begin errors++; $display("[TB] FAIL jump20_pc got %h exp %h", bus.o_pc, 32'h20); end
    checks++; if (bus.o_redirect_count !== 32'd1) begin errors++; $display("[TB] FAIL jump20_count got %0d exp 1", bus.o_redirect_count); end
    set_inputs(1'b1, 2'b11, 32'h0, 32'h80, 1'b0);
    #1;
    checks++; if (bus.o_flush_if_id !== 1'b1 || bus.o_flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL branch80_flush got %b%b exp 11", bus.o_flush_if_id, bus.o_flush_id_ex); end
    tick();
    checks++; if (bus.o_imem_addr !== 32'h80) begin errors++; $display("[TB] FAIL branch80_imem got %h exp %h", bus.o_imem_addr, 32'h80); end
    checks++; if (bus.o_redirect_count !== 32'd2) begin errors++; $display("[TB] FAIL branch80_count got %0d exp 2", bus.o_redirect_count); end
  endtask

  task automatic test_jump_stall();
    set_inputs(1'b1, 2'b01, 32'h41, 32'h0, 1'b1);
    #1;
    checks++; if (bus.o_flush_if_id !== 1'b1 || bus.o_flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL jumpstall_flush got %b%b exp 11", bus.o_flush_if_id, bus.o_flush_id_ex); end
    tick();
    checks++; if (bus.o_pc !== 32'h40) begin errors++; $display("[TB] FAIL jumpstall_pc got %h exp %h", bus.o_pc, 32'h40); end
    checks++; if (bus.o_redirect_count !== 32'd3) begin errors++; $display("[TB] FAIL jumpstall_count got %0d exp 3", bus.o_redirect_count); end
  endtask

  task automatic test_stall();
    set_inputs(1'b1, 2'b01, 32'h50, 32'h0, 1'b0);
    tick();
    checks++; if (bus.o_pc !== 32'h50) begin errors++; $display("[TB] FAIL stall_setup_pc got %h exp %h", bus.o_pc, 32'h50); end
    set_inputs(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.o_flush_if_id !== 1'b0 || bus.o_flush_id_ex !== 1'b0) begin errors++; $display("[TB] FAIL stall_flush[%0d] got %b%b exp 00", i, bus.o_flush_if_id, bus.o_flush_id_ex); end
      tick();
      checks++; if (bus.o_pc !== 32'h50) begin errors++; $display("[TB] FAIL stall_pc[%0d] got %h exp %h", i, bus.o_pc, 32'h50); end
    end
    set_inputs(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.o_pc !== 32'h54) begin errors++; $display("[TB] FAIL stall_resume_pc got %h exp %h", bus.o_pc, 32'h54); end
  endtask

  task automatic test_sequential_sel();
    set_inputs(1'b1, 2'b10, 32'h200, 32'h300, 1'b0);
    #1;
    checks++; if (bus.o_flush_if_id !== 1'b0 || bus.o_flush_id_ex !== 1'b0) begin errors++; $display("[TB] FAIL sel10_flush got %b%b exp 00", bus.o_flush_if_id, bus.o_flush_id_ex); end
    tick();
    checks++; if (bus.o_pc !== 32'h58) begin errors++; $display("[TB] FAIL sel10_pc got %h exp %h", bus.o_pc, 32'h58); end
    set_inputs(1'b1, 2'b00, 32'h200, 32'h300, 1'b0);
    tick();
    checks++; if (bus.o_pc !== 32'h5C) begin errors++; $display("[TB] FAIL sel00_pc got %h exp %h", bus.o_pc, 32'h5C); end
    checks++; if (bus.o_redirect_count !== 32'd4) begin errors++; $display("[TB] FAIL sel00_count got %0d exp 4", bus.o_redirect_count); end
  endtask

  task automatic test_wrap();
    set_inputs(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0);
    tick();
    checks++; if (bus.o_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_setup_pc got %h exp %h", bus.o_pc, 32'hFFFF_FFFC); end
    checks++; if (bus.o_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_plus4 got %h exp 0", bus.o_pc_plus4); end
    set_inputs(1'b0, 2'b11, 32'h0, 32'h80, 1'b0);
    #1;
    checks++; if (bus.o_flush_if_id !== 1'b0 || bus.o_flush_id_ex !== 1'b0) begin errors++; $display("[TB] FAIL novalid_flush got %b%b exp 00", bus.o_flush_if_id, bus.o_flush_id_ex); end
    tick();
    checks++; if (bus.o_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h exp 0", bus.o_pc); end
    checks++; if (bus.o_redirect_count !== 32'd5) begin errors++; $display("[TB] FAIL wrap_count got %0d exp 5", bus.o_redirect_count); end
  endtask

  task automatic test_trap();
    set_inputs(1'b1, 2'b11, 32'h0, 32'h106, 1'b1);
    #1;
    checks++; if (bus.o_flush_if_id !== 1'b1 || bus.o_flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL trap_flush got %b%b exp 11", bus.o_flush_if_id, bus.o_flush_id_ex); end
    tick();
    checks++; if (bus.o_trap !== 1'b1) begin errors++; $display("[TB] FAIL trap_flag got %b exp 1", bus.o_trap); end
    checks++; if (bus.o_trap_pc !== 32'h106) begin errors++; $display("[TB] FAIL trap_pc got %h exp %h", bus.o_trap_pc, 32'h106); end
    checks++; if (bus.o_fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL trap_fetch_valid got %b exp 0", bus.o_fetch_valid); end
    checks++; if (bus.o_pc !== 32'h0) begin errors++; $display("[TB] FAIL trap_pc_frozen got %h exp 0", bus.o_pc); end
    checks++; if (bus.o_redirect_count !== 32'd5) begin errors++; $display("[TB] FAIL trap_count got %0d exp 5", bus.o_redirect_count); end
    set_inputs(1'b1, 2'b01, 32'h200, 32'h0, 1'b0);
    #1;
    checks++; if (bus.o_flush_if_id !== 1'b0 || bus.o_flush_id_ex !== 1'b0) begin errors++; $display("[TB] FAIL halt_flush got %b%b exp 00", bus.o_flush_if_id, bus.o_flush_id_ex); end
    tick();
    tick();
    checks++; if (bus.o_pc !== 32'h0) begin errors++; $display("[TB] FAIL halt_pc got %h exp 0", bus.o_pc); end
    checks++; if (bus.o_trap !== 1'b1 || bus.o_trap_pc !== 32'h106) begin errors++; $display("[TB] FAIL halt_trap got %b/%h exp 1/%h", bus.o_trap, bus.o_trap_pc, 32'h106); end
  endtask

  task automatic test_reset_from_halt();
    rst_n = 1'b0;
    set_inputs(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.o_pc !== 32'h100) begin errors++; $display("[TB] FAIL rehalt_pc got %h exp %h", bus.o_pc, 32'h100); end
    checks++; if (bus.o_trap !== 1'b0 || bus.o_trap_pc !== 32'h0) begin errors++; $display("[TB] FAIL rehalt_trap got %b/%h exp 0/0", bus.o_trap, bus.o_trap_pc); end
    checks++; if (bus.o_redirect_count !== 32'h0) begin errors++; $display("[TB] FAIL rehalt_count got %h exp 0", bus.o_redirect_count); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.o_fetch_valid !== 1'b1 || bus.o_pc !== 32'h100) begin errors++; $display("[TB] FAIL rehalt_run got %b/%h exp 1/%h", bus.o_fetch_valid, bus.o_pc, 32'h100); end
  endtask

  task automatic test_jalr_trap();
    set_inputs(1'b1, 2'b01, 32'h43, 32'h0, 1'b0);
    tick();
    checks++; if (bus.o_trap !== 1'b1 || bus.o_trap_pc !== 32'h42) begin errors++; $display("[TB] FAIL jalr_trap got %b/%h exp 1/%h", bus.o_trap, bus.o_trap_pc, 32'h42); end
    checks++; if (bus.o_pc !== 32'h100) begin errors++; $display("[TB] FAIL jalr_trap_pc got %h exp %h", bus.o_pc, 32'h100); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_inputs(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_branch();
    test_jump_stall();
    test_stall();
    test_sequential_sel();
    test_wrap();
    test_trap();
    test_reset_from_halt();
    test_jalr_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
